// File: rtl/systolic_drain.sv
// systolic_drain
//   Buffers complete result rows from a systolic core and serializes them
//   one element per transfer, lowest column first.
//
//   Parameters
//     ARRAY_SIZE   elements per result row (at least 2)
//     DATA_WIDTH   core operand width
//     ACC_WIDTH    width of one result element
//     DEPTH        row buffer depth, power of two, at least 2
//
//   Ports
//     clk            rising-edge clock
//     reset          asynchronous, active-high
//     row_valid      row_data holds a complete row
//     row_data       row; element c at [c*ACC_WIDTH +: ACC_WIDTH]
//     row_ready      buffer can accept a row
//     out_valid      out_data/out_col/out_last are valid
//     out_ready      downstream accepts the current element
//     out_data       serialized element
//     out_col        column index of out_data
//     out_last       out_col is the final column
//     rows_pending   rows stored, including the one being serialized
//     overflow       sticky: a row was presented while row_ready was low
module systolic_drain #(
   parameter int ARRAY_SIZE = 8,
   parameter int DATA_WIDTH = 4,
   parameter int ACC_WIDTH  = DATA_WIDTH * DATA_WIDTH,
   parameter int DEPTH      = 4
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                row_valid,
   input  logic [ARRAY_SIZE*ACC_WIDTH-1:0]     row_data,
   output logic                                row_ready,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic [ACC_WIDTH-1:0]                out_data,
   output logic [$clog2(ARRAY_SIZE)-1:0]       out_col,
   output logic                                out_last,
   output logic [$clog2(DEPTH):0]              rows_pending,
   output logic                                overflow
);

   localparam int ROW_W = ARRAY_SIZE * ACC_WIDTH;
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int COL_W = $clog2(ARRAY_SIZE);

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   state_t             state, state_nxt;
   logic [COL_W-1:0]   col, col_nxt;
   logic [CNT_W-1:0]   count;
   logic [PTR_W-1:0]   wr_ptr, rd_ptr;
   logic [ROW_W-1:0]   mem [DEPTH];
   logic [ROW_W-1:0]   head_row;
   logic               push, pop;

   // row_ready depends only on registered occupancy, so a pop on the same
   // edge cannot open a slot while the buffer is full.
   assign row_ready    = (count != CNT_W'(DEPTH));
   assign push         = row_valid && row_ready;
   assign rows_pending = count;
   assign out_valid    = (state == SEND);
   assign out_col      = col;
   assign out_last     = (col == COL_W'(ARRAY_SIZE - 1));
   assign head_row     = mem[rd_ptr];

   // The head slot is never the write target while SEND is active, so the
   // element held under backpressure stays stable.
   always_comb begin
      out_data = '0;
      if (state == SEND)
         out_data = head_row[col*ACC_WIDTH +: ACC_WIDTH];
   end

   always_comb begin
      state_nxt = state;
      col_nxt   = col;
      pop       = 1'b0;
      case (state)
         IDLE: begin
            if (count != '0) begin
               state_nxt = SEND;
               col_nxt   = '0;
            end
         end
         SEND: begin
            if (out_ready) begin
               if (out_last) begin
                  pop     = 1'b1;
                  col_nxt = '0;
                  // Stay in SEND when a row remains after the pop, including
                  // one pushed on this same edge, so there is no bubble.
                  if (count == CNT_W'(1) && !push)
                     state_nxt = IDLE;
               end else begin
                  col_nxt = col + 1'b1;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
            col_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         col      <= '0;
         count    <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         overflow <= 1'b0;
      end else begin
         col <= col_nxt;
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (row_valid && !row_ready)
            overflow <= 1'b1;
      end
   end

   // Row storage carries no reset; pointers and occupancy define validity.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= row_data;
   end

endmodule
